port_out_uart: RTL and testbench

Output peripheral downstream of the MIPS processor's 32-bit output port. It accepts words written by the processor, buffers them in a small FIFO, and serializes each word onto a UART line as four 8N1 bytes, least-significant byte first. It gives software a word-at-a-time output channel without stalling the pipeline. The processor sees back-pressure only through `Full`.

---
 rtl/port_out_uart.sv | 148 ++++++++++++++
 tb/tb_port_out_uart.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_out_uart.sv
// rtl/port_out_uart.sv - word FIFO feeding a 4-byte 8N1 UART serializer, LSB byte first
module port_out_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PortData,
    input  logic        PortWrite,
    output logic        Tx,
    output logic        Busy,
    output logic        Full,
    output logic        Overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   shift_q, shift_d;
    logic [7:0]    cur_byte;

    logic empty, pop, push, baud_done;

    assign empty     = (count_q == '0);
    assign Full      = (count_q == CW'(FIFO_DEPTH));
    assign pop       = (state_q == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
    assign push      = PortWrite && (!Full || pop);
    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign cur_byte  = shift_q[7:0];
    assign Busy      = (state_q != IDLE) || !empty;
    assign Overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= PortData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (PortWrite && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
        end
    end

    // Tx is decoded from state so an asynchronous reset forces the line idle at once.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        Tx      = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    shift_d = mem_q[rd_ptr_q];
                    byte_d  = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                Tx = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                Tx = cur_byte[bit_q];
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shift_d = shift_q >> 8;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_port_out_uart.sv
// tb/tb_port_out_uart.sv - directed bench for port_out_uart with a cycle-exact UART line monitor
module tb_port_out_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PortData;
    logic        PortWrite;
    logic        Tx, Busy, Full, Overflow;

    port_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .PortData (PortData),
        .PortWrite(PortWrite),
        .Tx       (Tx),
        .Busy     (Busy),
        .Full     (Full),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [7:0] rx_data_q[$];
    bit         rx_ok_q[$];
    int         rx_cyc_q[$];

    bit         mon_in;
    int         mon_pos;
    int         mon_st;
    logic [9:0] mon_bits;
    logic       mon_cur;
    bit         mon_glitch;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_data_q.delete();
        rx_ok_q.delete();
        rx_cyc_q.delete();
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        clear_rx();
        step();
    endtask

    task automatic wait_idle(input string nm, input int max, output int n);
        n = 0;
        while ((Busy !== 1'b0) && (n < max)) begin
            step();
            n++;
        end
        chk({nm, " idle_timeout"}, (n < max), 1);
    endtask

    task automatic pop_word(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, output int st);
        logic [31:0] got;
        bit          ok;
        bit          spc;
        int          c[4];
        st = -1;
        chk({nm, " avail"}, (rx_data_q.size() >= 4), 1);
        if (rx_data_q.size() < 4) return;
        ok  = 1'b1;
        spc = 1'b1;
        for (int j = 0; j < 4; j++) begin
            got[8*j +: 8] = rx_data_q.pop_front();
            ok            = ok & rx_ok_q.pop_front();
            c[j]          = rx_cyc_q.pop_front();
        end
        for (int j = 1; j < 4; j++) begin
            if (c[j] - c[j-1] != 10 * CPB) spc = 1'b0;
        end
        st = c[0];
        chk({nm, " data"}, got, {e3, e2, e1, e0});
        chk({nm, " framing"}, ok, 1);
        chk({nm, " byte_spacing"}, spc, 1);
    endtask

    // Line receiver: every cycle of a bit must hold the same level.
    initial begin
        mon_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset !== 1'b1) begin
                mon_in = 1'b0;
            end else begin
                if (!mon_in && Tx === 1'b0) begin
                    mon_in     = 1'b1;
                    mon_pos    = 0;
                    mon_st     = cyc;
                    mon_glitch = 1'b0;
                    mon_bits   = '0;
                end
                if (mon_in) begin
                    if (mon_pos % CPB == 0) mon_cur = Tx;
                    else if (Tx !== mon_cur) mon_glitch = 1'b1;
                    if (mon_pos % CPB == CPB - 1) mon_bits[mon_pos / CPB] = mon_cur;
                    mon_pos++;
                    if (mon_pos == 10 * CPB) begin
                        rx_data_q.push_back(mon_bits[8:1]);
                        rx_ok_q.push_back(mon_bits[0] == 1'b0 && mon_bits[9] == 1'b1 && !mon_glitch);
                        rx_cyc_q.push_back(mon_st);
                        mon_in = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, st, prev, err;
        reset     = 1'b0;
        PortWrite = 1'b0;
        PortData  = '0;
        #1;
        chk("reset Tx", Tx, 1);
        chk("reset Busy", Busy, 0);
        chk("reset Full", Full, 0);
        chk("reset Overflow", Overflow, 0);
        step();
        step();
        reset = 1'b1;

        err = 0;
        repeat (100) begin
            step();
            if (Tx !== 1'b1 || Busy !== 1'b0 || Full !== 1'b0 || Overflow !== 1'b0) err++;
        end
        chk("idle_100 bad_cycles", err, 0);

        vecs[0] = '{32'hA5C30F81, 8'h81, 8'h0F, 8'hC3, 8'hA5};
        vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
        vecs[4] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80};

        foreach (vecs[i]) begin
            clear_rx();
            PortData  = vecs[i].word;
            PortWrite = 1'b1;
            step();
            PortWrite = 1'b0;
            chk($sformatf("v%0d busy_after_write", i), Busy, 1);
            chk($sformatf("v%0d tx_high_edge_k", i), Tx, 1);
            step();
            chk($sformatf("v%0d tx_low_edge_k1", i), Tx, 0);
            wait_idle($sformatf("v%0d", i), 1000, n);
            chk($sformatf("v%0d duration", i), n, 40 * CPB);
            step();
            pop_word($sformatf("v%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, st);
            chk($sformatf("v%0d extra_bytes", i), rx_data_q.size(), 0);
        end

        // Six back-to-back writes: one pops immediately, four fill the FIFO, the sixth drops.
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            PortData  = 32'(i + 1);
            PortWrite = 1'b1;
            step();
            if (i == 0) chk("burst tx_idle_edge1", Tx, 1);
            if (i == 1) chk("burst pop_edge2", Tx, 0);
            if (i == 3) chk("burst not_full_edge4", Full, 0);
            if (i == 4) begin
                chk("burst full_edge5", Full, 1);
                chk("burst no_overflow_edge5", Overflow, 0);
            end
            if (i == 5) begin
                chk("burst overflow_edge6", Overflow, 1);
                chk("burst still_full_edge6", Full, 1);
            end
        end
        PortWrite = 1'b0;
        wait_idle("burst", 2000, n);
        step();
        prev = 0;
        for (int w = 0; w < 5; w++) begin
            pop_word($sformatf("burst w%0d", w + 1), 8'(w + 1), 8'h00, 8'h00, 8'h00, st);
            if (w > 0) chk($sformatf("burst gap w%0d", w + 1), st - prev, 40 * CPB + 1);
            prev = st;
        end
        chk("burst extra_bytes", rx_data_q.size(), 0);
        chk("burst overflow_sticky", Overflow, 1);
        chk("burst full_cleared", Full, 0);

        // Write lands on the IDLE pop cycle while full: accepted without overflow.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            PortData  = 32'hA0 + 32'(i);
            PortWrite = 1'b1;
            step();
        end
        PortWrite = 1'b0;
        chk("popwr full", Full, 1);
        chk("popwr overflow_pre", Overflow, 0);
        repeat (40 * CPB - 3) step();
        chk("popwr idle_tx", Tx, 1);
        chk("popwr idle_full", Full, 1);
        PortData  = 32'h12345678;
        PortWrite = 1'b1;
        step();
        PortWrite = 1'b0;
        chk("popwr full_after", Full, 1);
        chk("popwr overflow_after", Overflow, 0);
        chk("popwr next_start", Tx, 0);
        wait_idle("popwr", 3000, n);
        step();
        prev = 0;
        for (int w = 0; w < 5; w++) begin
            pop_word($sformatf("popwr w%0d", w), 8'hA0 + 8'(w), 8'h00, 8'h00, 8'h00, st);
            if (w > 0) chk($sformatf("popwr gap w%0d", w), st - prev, 40 * CPB + 1);
            prev = st;
        end
        pop_word("popwr last", 8'h78, 8'h56, 8'h34, 8'h12, st);
        chk("popwr gap last", st - prev, 40 * CPB + 1);
        chk("popwr extra_bytes", rx_data_q.size(), 0);

        // Reset in byte 2, DATA bit 3 (line low there since 0xF7 bit 3 is 0).
        reset_dut();
        PortData  = 32'h00F70000;
        PortWrite = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            PortData = 32'h11111111;
            step();
        end
        PortWrite = 1'b0;
        chk("midrst full_pre", Full, 1);
        repeat (94) step();
        chk("midrst tx_bit3", Tx, 0);
        reset = 1'b0;
        #1;
        chk("midrst tx_async", Tx, 1);
        chk("midrst busy", Busy, 0);
        chk("midrst full", Full, 0);
        chk("midrst overflow", Overflow, 0);
        step();
        step();
        reset = 1'b1;
        clear_rx();
        err = 0;
        repeat (50) begin
            step();
            if (Tx !== 1'b1 || Busy !== 1'b0) err++;
        end
        chk("midrst quiet_after_release", err, 0);
        PortData  = 32'h000000FF;
        PortWrite = 1'b1;
        step();
        PortWrite = 1'b0;
        wait_idle("midrst", 1000, n);
        repeat (20) step();
        pop_word("midrst frame", 8'hFF, 8'h00, 8'h00, 8'h00, st);
        chk("midrst extra_bytes", rx_data_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
